// File: rtl/usb_line_dir_ctrl.sv
// usb_line_dir_ctrl
// Decides who owns the D+/D- lines: the RX path or the TX encoder.
// Before a TX grant the bus must stay idle for an inter-packet gap.
// After TX the block drives EOP (SE0, then J), then holds the bus
// released for a hold-off window before the next grant.
// All outputs are registered decodes of the next state, so they line up
// cycle-for-cycle with the state register.

module usb_line_dir_ctrl #(
    parameter int CLKS_PER_BIT = 8,
    parameter int IPG_BITS     = 2,
    parameter int SE0_BITS     = 2,
    parameter int HOLD_BITS    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_req,
    input  logic tx_done,
    input  logic rx_active,
    output logic tx_grant,
    output logic transmitting,
    output logic transmit_eop,
    output logic eop_d_plus,
    output logic eop_d_minus,
    output logic bus_busy,
    output logic collision
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_TX,
        S_EOP_SE0,
        S_EOP_J,
        S_HOLD
    } state_t;

    // Largest bit count any timed state needs to reach.
    localparam int MAX_A    = (IPG_BITS > SE0_BITS) ? IPG_BITS : SE0_BITS;
    localparam int MAX_BITS = (MAX_A > HOLD_BITS) ? MAX_A : HOLD_BITS;
    localparam int CLK_W    = $clog2(CLKS_PER_BIT);
    localparam int BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] IPG_LAST = BIT_W'(IPG_BITS - 1);
    localparam logic [BIT_W-1:0] SE0_LAST = BIT_W'(SE0_BITS - 1);
    localparam logic [BIT_W-1:0] HLD_LAST = BIT_W'(HOLD_BITS - 1);

    state_t           state;
    state_t           next_state;
    logic [CLK_W-1:0] clk_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             clk_wrap;
    logic             rx_active_d;
    logic             coll_seen;
    logic             coll_hit;

    assign clk_wrap = (clk_cnt == CLK_LAST);

    // A collision is the first rising edge of rx_active within one TX visit.
    assign coll_hit = (state == S_TX) && rx_active && !rx_active_d && !coll_seen;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always written with <= so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision from the current state, timers and inputs.
    always_comb begin
        // NOTE: next_state gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_state = state;
        unique case (state)
            S_IDLE: begin
                // RX owns the bus whenever it is active.
                if (tx_req && !rx_active) next_state = S_GAP;
            end
            S_GAP: begin
                if (rx_active || !tx_req)            next_state = S_IDLE;
                else if (clk_wrap && bit_cnt == IPG_LAST) next_state = S_TX;
            end
            S_TX: begin
                if (tx_done) next_state = S_EOP_SE0;
            end
            S_EOP_SE0: begin
                if (clk_wrap && bit_cnt == SE0_LAST) next_state = S_EOP_J;
            end
            S_EOP_J: begin
                if (clk_wrap) next_state = S_HOLD;
            end
            S_HOLD: begin
                if (clk_wrap && bit_cnt == HLD_LAST) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Bit-time counters; restart from zero on every state entry.
    always_ff @(posedge clk) begin
        if (rst || next_state != state) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
        end else if (clk_wrap) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
        end else begin
            clk_cnt <= clk_cnt + 1'b1;
        end
    end

    // Collision tracking: remember rx_active and whether this TX visit already flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_active_d <= 1'b0;
            coll_seen   <= 1'b0;
        end else begin
            rx_active_d <= rx_active;
            if (next_state == S_TX && state != S_TX) coll_seen <= 1'b0;
            else if (coll_hit)                       coll_seen <= 1'b1;
        end
    end

    // Registered output decode of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_grant     <= 1'b0;
            transmitting <= 1'b0;
            transmit_eop <= 1'b0;
            eop_d_plus   <= 1'b0;
            eop_d_minus  <= 1'b0;
            bus_busy     <= 1'b0;
            collision    <= 1'b0;
        end else begin
            tx_grant     <= (next_state == S_TX) && (state != S_TX);
            transmitting <= (next_state == S_TX);
            transmit_eop <= (next_state == S_EOP_SE0) || (next_state == S_EOP_J);
            // J state is D+ high, D- low; SE0 drives both low.
            eop_d_plus   <= (next_state == S_EOP_J);
            eop_d_minus  <= 1'b0;
            bus_busy     <= (next_state != S_IDLE);
            collision    <= coll_hit;
        end
    end

endmodule

// File: tb/tb_usb_line_dir_ctrl.sv
// Testbench for usb_line_dir_ctrl.
// A countdown-timer reference model predicts every output cycle; the
// prediction is queued when inputs are driven and compared after the edge.
// Each scenario task also checks the absolute cycle timing directly.

module tb_usb_line_dir_ctrl;

    localparam int CPB      = 8;
    localparam int GAP_CYC  = 2 * CPB;
    localparam int SE0_CYC  = 2 * CPB;
    localparam int HOLD_CYC = 4 * CPB;

    logic clk = 1'b0;
    logic rst, tx_req, tx_done, rx_active;
    logic tx_grant, transmitting, transmit_eop, eop_d_plus, eop_d_minus, bus_busy, collision;

    int checks = 0;
    int errors = 0;

    typedef enum int {M_IDLE, M_GAP, M_TX, M_SE0, M_J, M_HOLD} m_state_t;
    m_state_t   m_state = M_IDLE;
    int         m_timer = 0;
    logic       m_rx_d = 1'b0;
    logic       m_collided = 1'b0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    usb_line_dir_ctrl #(
        .CLKS_PER_BIT(CPB), .IPG_BITS(2), .SE0_BITS(2), .HOLD_BITS(4)
    ) dut (
        .clk(clk), .rst(rst), .tx_req(tx_req), .tx_done(tx_done), .rx_active(rx_active),
        .tx_grant(tx_grant), .transmitting(transmitting), .transmit_eop(transmit_eop),
        .eop_d_plus(eop_d_plus), .eop_d_minus(eop_d_minus), .bus_busy(bus_busy),
        .collision(collision)
    );

    function automatic logic [6:0] obs();
        return {tx_grant, transmitting, transmit_eop, eop_d_plus, eop_d_minus, bus_busy, collision};
    endfunction

    // Advance one clock: predict outputs from current inputs, queue them,
    // clock the DUT, then compare what it produced against the queue head.
    task automatic step();
        m_state_t ns;
        int       nt;
        logic     ncoll;
        logic [6:0] got, exp_v;
        ns = m_state;
        nt = m_timer;
        ncoll = 1'b0;
        if (rst) begin
            ns = M_IDLE; nt = 0;
        end else begin
            case (m_state)
                M_IDLE: if (tx_req && !rx_active) begin ns = M_GAP; nt = GAP_CYC; end
                M_GAP:  if (rx_active || !tx_req) ns = M_IDLE;
                        else if (m_timer == 1) ns = M_TX;
                        else nt = m_timer - 1;
                M_TX:   if (tx_done) begin ns = M_SE0; nt = SE0_CYC; end
                M_SE0:  if (m_timer == 1) begin ns = M_J; nt = CPB; end else nt = m_timer - 1;
                M_J:    if (m_timer == 1) begin ns = M_HOLD; nt = HOLD_CYC; end else nt = m_timer - 1;
                M_HOLD: if (m_timer == 1) ns = M_IDLE; else nt = m_timer - 1;
                default: ns = M_IDLE;
            endcase
            ncoll = (m_state == M_TX) && rx_active && !m_rx_d && !m_collided;
        end
        exp_v = {(ns == M_TX) && (m_state != M_TX) && !rst,
                 ns == M_TX,
                 (ns == M_SE0) || (ns == M_J),
                 ns == M_J,
                 1'b0,
                 ns != M_IDLE,
                 ncoll};
        exp_q.push_back(exp_v);
        if (rst) begin
            m_rx_d = 1'b0; m_collided = 1'b0;
        end else begin
            if (ns == M_TX && m_state != M_TX) m_collided = 1'b0;
            else if (ncoll) m_collided = 1'b1;
            m_rx_d = rx_active;
        end
        m_state = ns;
        m_timer = nt;
        @(posedge clk);
        #1;
        got = obs();
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL scoreboard t=%0t got=%b expected=%b (grant,tx,eop,dp,dm,busy,coll)", $time, got, exp_v);
        end
    endtask

    // Finish an outstanding packet and wait, bounded, for the bus to go idle.
    task automatic drain();
        int n;
        tx_req = 1'b0; rx_active = 1'b0; rst = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        n = 0;
        while (bus_busy === 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout bus_busy=%b required=0", bus_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_req = 1'b1; tx_done = 1'b1; rx_active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs() !== 7'b0) begin
                errors++;
                $display("FAIL reset_outputs got=%b required=0000000", obs());
            end
        end
        rst = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int o;
        for (int c = 0; c < 100; c++) begin
            tx_req  = (c < 17);
            tx_done = (c == 40);
            step();
            o = c + 1;
            if (o == 17 || (o >= 41 && o <= 65) || o == 97) checks++;
            if (o == 17 && {tx_grant, transmitting} !== 2'b11) begin
                errors++; $display("FAIL basic_grant cyc=%0d got=%b required=11", o, {tx_grant, transmitting});
            end
            if (o >= 41 && o <= 56 && {transmit_eop, eop_d_plus, eop_d_minus, transmitting} !== 4'b1000) begin
                errors++; $display("FAIL basic_se0 cyc=%0d got=%b required=1000", o, {transmit_eop, eop_d_plus, eop_d_minus, transmitting});
            end
            if (o >= 57 && o <= 64 && {transmit_eop, eop_d_plus, eop_d_minus, transmitting} !== 4'b1100) begin
                errors++; $display("FAIL basic_j cyc=%0d got=%b required=1100", o, {transmit_eop, eop_d_plus, eop_d_minus, transmitting});
            end
            if (o == 65 && {bus_busy, transmit_eop, eop_d_plus, transmitting} !== 4'b1000) begin
                errors++; $display("FAIL basic_hold cyc=%0d got=%b required=1000", o, {bus_busy, transmit_eop, eop_d_plus, transmitting});
            end
            if (o == 97 && bus_busy !== 1'b0) begin
                errors++; $display("FAIL basic_idle cyc=%0d bus_busy=%b required=0", o, bus_busy);
            end
        end
        tx_done = 1'b0;
    endtask

    task automatic test_rx_priority();
        int grant_at = -1;
        for (int c = 0; c < 80 && grant_at < 0; c++) begin
            tx_req    = 1'b1;
            rx_active = (c < 30);
            step();
            if (c + 1 <= 30) begin
                checks++;
                if (bus_busy !== 1'b0) begin
                    errors++; $display("FAIL rx_priority_busy cyc=%0d bus_busy=%b required=0", c + 1, bus_busy);
                end
            end
            if (tx_grant === 1'b1) grant_at = c + 1;
        end
        checks++;
        if (grant_at != 47) begin
            errors++; $display("FAIL rx_priority_grant got=%0d required=47", grant_at);
        end
        drain();
    endtask

    task automatic test_gap_interrupt();
        int grant_at = -1;
        for (int c = 0; c < 60 && grant_at < 0; c++) begin
            tx_req    = 1'b1;
            rx_active = (c == 10);
            step();
            if (c + 1 == 11) begin
                checks++;
                if (bus_busy !== 1'b0) begin
                    errors++; $display("FAIL gap_abort bus_busy=%b required=0", bus_busy);
                end
            end
            if (tx_grant === 1'b1) grant_at = c + 1;
        end
        checks++;
        if (grant_at != 28) begin
            errors++; $display("FAIL gap_restart_grant got=%0d required=28", grant_at);
        end
        drain();
    endtask

    task automatic test_collision();
        int coll_cnt = 0;
        int coll_at = -1;
        for (int c = 0; c < 46; c++) begin
            tx_req    = (c < 17);
            rx_active = (c >= 20 && c < 23) || (c >= 25 && c < 27);
            tx_done   = (c == 30);
            step();
            if (collision === 1'b1) begin
                coll_cnt++;
                coll_at = c + 1;
            end
            if (c + 1 >= 17 && c + 1 <= 30) begin
                checks++;
                if (transmitting !== 1'b1) begin
                    errors++; $display("FAIL collision_tx_hold cyc=%0d transmitting=%b required=1", c + 1, transmitting);
                end
            end
        end
        checks++;
        if (coll_cnt != 1 || coll_at != 21) begin
            errors++; $display("FAIL collision_pulse count=%0d at=%0d required count=1 at=21", coll_cnt, coll_at);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int early = 0;
        int grant2 = -1;
        for (int c = 0; c < 131; c++) begin
            tx_req  = (c < 114);
            tx_done = (c == 40) || (c == 114);
            rx_active = 1'b0;
            step();
            if (tx_grant === 1'b1 && c + 1 > 17 && c + 1 < 114) early++;
            if (tx_grant === 1'b1 && c + 1 >= 114 && grant2 < 0) grant2 = c + 1;
            if (c + 1 == 115) begin
                checks++;
                if ({transmitting, transmit_eop} !== 2'b01) begin
                    errors++; $display("FAIL one_cycle_tx got=%b required=01", {transmitting, transmit_eop});
                end
            end
        end
        checks++;
        if (early != 0 || grant2 != 114) begin
            errors++; $display("FAIL holdoff_grant early=%0d second=%0d required early=0 second=114", early, grant2);
        end
        drain();
    endtask

    task automatic test_reset_mid_eop();
        for (int c = 0; c < 46; c++) begin
            tx_req  = (c < 17);
            tx_done = (c == 20) || (c == 27);
            rst     = (c == 25);
            step();
            if (c + 1 == 25) begin
                checks++;
                if (transmit_eop !== 1'b1) begin
                    errors++; $display("FAIL mid_eop_setup transmit_eop=%b required=1", transmit_eop);
                end
            end
            if (c + 1 >= 26) begin
                checks++;
                if (obs() !== 7'b0) begin
                    errors++; $display("FAIL reset_mid_eop cyc=%0d got=%b required=0000000", c + 1, obs());
                end
            end
        end
        rst = 1'b0; tx_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tx_req = 1'b0; tx_done = 1'b0; rx_active = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_rx_priority();
        test_gap_interrupt();
        test_collision();
        test_back_to_back();
        test_reset_mid_eop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_line_dir_ctrl.md
Name: usb_line_dir_ctrl

Overview:
- Sequences D+/D- line ownership between the USB RX path and the TX encoder.
- Generates the transmitting, transmit_eop and EOP line values consumed by the USB transceiver selector.
- Enforces the inter-packet gap before TX, drives the EOP (SE0 then J) after TX, and applies a post-packet hold-off before the next grant.

Parameters:
CLKS_PER_BIT, 8, system clocks per USB bit time (>=2)
IPG_BITS, 2, idle bit times required before a TX grant (>=1)
SE0_BITS, 2, bit times of SE0 in EOP (>=1)
HOLD_BITS, 4, bit times after EOP during which tx_req is ignored (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
tx_req  in  1  level; TX encoder wants the bus; held until tx_grant
tx_done  in  1  one-cycle pulse; encoder has sent its final bit
rx_active  in  1  level; RX decoder is inside a packet
tx_grant  out  1  one-cycle pulse on the first TX cycle
transmitting  out  1  high throughout TX state
transmit_eop  out  1  high throughout EOP_SE0 and EOP_J
eop_d_plus  out  1  D+ value to drive during EOP
eop_d_minus  out  1  D- value to drive during EOP
bus_busy  out  1  high in every state except IDLE
collision  out  1  one-cycle pulse: rx_active seen high while in TX

Behaviour:
- Reset: state=IDLE; counters=0; all outputs 0. Synchronous reset wins over every other input, including mid-packet; lines are released on the next edge.
- Outputs are registered Moore decodes of state; collision and tx_grant are registered pulses.
- Counters:
  - clk_cnt counts 0..CLKS_PER_BIT-1 and wraps.
  - bit_cnt increments on the clk_cnt wrap.
  - Both clear on every state entry.
  - Widths are $clog2 of the maximum needed value.
- IDLE: if tx_req=1 and rx_active=0 -> GAP. If rx_active=1, stay (RX has priority).
- GAP:
  - Lasts IPG_BITS*CLKS_PER_BIT cycles.
  - rx_active=1 on any GAP cycle -> IDLE, counters cleared; gap restarts from zero later.
  - tx_req dropping -> IDLE.
  - On completion -> TX.
- TX:
  - transmitting=1; tx_grant=1 on the first TX cycle only.
  - tx_done=1 -> EOP_SE0 next cycle.
  - rx_active is ignored for state purposes; its rising edge in TX produces a collision pulse (one per TX visit).
  - No timeout.
- EOP_SE0: transmit_eop=1, eop_d_plus=0, eop_d_minus=0 for SE0_BITS*CLKS_PER_BIT cycles, then -> EOP_J.
- EOP_J: transmit_eop=1, eop_d_plus=1, eop_d_minus=0 for CLKS_PER_BIT cycles, then -> HOLD.
- HOLD: all line outputs 0 (released); tx_req ignored for HOLD_BITS*CLKS_PER_BIT cycles, then -> IDLE.
- tx_done outside TX is ignored. eop_d_* are 0 outside EOP states.
- transmitting and transmit_eop are never both high.
- Latency: tx_req rising at edge N (bus idle) -> GAP at N+1 -> tx_grant/transmitting at N+1+IPG_BITS*CLKS_PER_BIT.
- Same-cycle events:
  - tx_req and rx_active both high in IDLE -> stay IDLE.
  - tx_done in the same cycle as tx_grant -> TX lasts exactly one cycle.

Test Plan (defaults):
- Basic packet: rst, then tx_req=1 at cycle 0, rx_active=0.
  - tx_grant pulse and transmitting=1 at cycle 17.
  - tx_done at cycle 40 -> transmit_eop=1 with SE0 cycles 41-56, J (1/0) cycles 57-64.
  - Released with bus_busy=1 cycles 65-96; IDLE and bus_busy=0 at 97.
- RX priority: rx_active=1 and tx_req=1 for 30 cycles -> no GAP, bus_busy=0. Drop rx_active at cycle 30 -> tx_grant at cycle 47.
- Gap interrupt: rx_active pulses high at the 10th GAP cycle -> state IDLE. Grant arrives a full 16 cycles after the next GAP entry.
- Collision: rx_active rises mid-TX -> exactly one collision pulse; transmitting stays 1 until tx_done.
- Hold-off: tx_req held high through HOLD -> no tx_grant before IDLE. Next grant at HOLD end + 1 + 16 cycles.
- Reset mid-EOP: rst asserted on the 5th EOP_SE0 cycle -> next cycle all outputs 0, state IDLE. Stray tx_done afterwards has no effect.
